// File: rtl/reloj_main.sv
// 24-hour clock with one alarm and a 4-digit multiplexed 7-segment display.
// Optional build macro: RELOJ_LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit.
module reloj_main #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int REFRESH_DIV = 50_000
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       MoDe,
  input  logic       AjusTHora,
  input  logic       AjusTAlarma,
  input  logic       AumenMin,
  input  logic       AumenHora,
  output logic       Segundo,
  output logic       alarma,
  output logic       Sw0,
  output logic       Sw1,
  output logic       Sw2,
  output logic       Sw3,
  output logic [6:0] Displaytotal
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF  = PW'(CLK_HZ / 2);
  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    hr_q, hr_d;
  logic [7:0]    alm_min_q, alm_min_d;
  logic [7:0]    alm_hr_q, alm_hr_d;
  logic          armed_q, armed_d;
  logic          segundo_q, segundo_d;
  logic          alarma_q, alarma_d;
  logic [1:0]    min_sync_q, min_sync_d;
  logic [1:0]    hr_sync_q, hr_sync_d;
  logic          min_prev_q, min_prev_d;
  logic          hr_prev_q, hr_prev_d;
  logic [RW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    digit_q, digit_d;

  logic          min_edge_s;
  logic          hr_edge_s;
  logic [7:0]    disp_min_s;
  logic [7:0]    disp_hr_s;
  logic [3:0]    digit_val_s;
  logic [3:0]    sw_s;
  logic [6:0]    seg_s;

  // BCD increment of a two-digit field that wraps to 00 after top.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top) begin
      bcd_inc = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      bcd_inc = {v[7:4] + 4'd1, 4'd0};
    end else begin
      bcd_inc = {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Button synchronizers and rising-edge detectors.
  always_comb begin
    min_sync_d = {min_sync_q[0], AumenMin};
    hr_sync_d  = {hr_sync_q[0], AumenHora};
    min_prev_d = min_sync_q[1];
    hr_prev_d  = hr_sync_q[1];
    min_edge_s = min_sync_q[1] & ~min_prev_q;
    hr_edge_s  = hr_sync_q[1] & ~hr_prev_q;
  end

  // Prescaler, timekeeping, adjust paths and registered status outputs.
  always_comb begin
    presc_d   = presc_q;
    sec_d     = sec_q;
    min_d     = min_q;
    hr_d      = hr_q;
    alm_min_d = alm_min_q;
    alm_hr_d  = alm_hr_q;
    armed_d   = armed_q;

    if (AjusTHora) begin
      // Prescaler frozen here, so a seconds carry can never collide with a press.
      presc_d = '0;
      sec_d   = 8'h00;
      if (min_edge_s) begin
        min_d = bcd_inc(min_q, 8'h59);
      end else begin
        min_d = min_q;
      end
      if (hr_edge_s) begin
        hr_d = bcd_inc(hr_q, 8'h23);
      end else begin
        hr_d = hr_q;
      end
    end else begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        sec_d   = bcd_inc(sec_q, 8'h59);
        if (sec_q == 8'h59) begin
          min_d = bcd_inc(min_q, 8'h59);
          if (min_q == 8'h59) begin
            hr_d = bcd_inc(hr_q, 8'h23);
          end else begin
            hr_d = hr_q;
          end
        end else begin
          min_d = min_q;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end

      if (AjusTAlarma) begin
        if (min_edge_s) begin
          alm_min_d = bcd_inc(alm_min_q, 8'h59);
          armed_d   = 1'b1;
        end else begin
          alm_min_d = alm_min_q;
        end
        if (hr_edge_s) begin
          alm_hr_d = bcd_inc(alm_hr_q, 8'h23);
          armed_d  = 1'b1;
        end else begin
          alm_hr_d = alm_hr_q;
        end
      end else begin
        alm_min_d = alm_min_q;
        alm_hr_d  = alm_hr_q;
      end
    end

    segundo_d = (presc_d < PRESC_HALF);
    alarma_d  = armed_d & (hr_d == alm_hr_d) & (min_d == alm_min_d)
                & ~AjusTHora & ~AjusTAlarma;
  end

  // Display scan counter: one digit per REFRESH_DIV cycles.
  always_comb begin
    if (scan_cnt_q == REFRESH_MAX) begin
      scan_cnt_d = '0;
      digit_d    = digit_q + 2'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + RW'(1);
      digit_d    = digit_q;
    end
  end

  // Digit select and segment decode from registered scan state.
  always_comb begin
    if (MoDe) begin
      disp_min_s = alm_min_q;
      disp_hr_s  = alm_hr_q;
    end else begin
      disp_min_s = min_q;
      disp_hr_s  = hr_q;
    end
    case (digit_q)
      2'd0:    begin digit_val_s = disp_min_s[3:0]; sw_s = 4'b1110; end
      2'd1:    begin digit_val_s = disp_min_s[7:4]; sw_s = 4'b1101; end
      2'd2:    begin digit_val_s = disp_hr_s[3:0];  sw_s = 4'b1011; end
      2'd3:    begin digit_val_s = disp_hr_s[7:4];  sw_s = 4'b0111; end
      default: begin digit_val_s = 4'd0;            sw_s = 4'b1110; end
    endcase
`ifdef RELOJ_LEADING_ZERO_BLANK_EN
    if ((digit_q == 2'd3) && (digit_val_s == 4'd0)) begin
      seg_s = 7'b1111111;
    end else begin
      seg_s = seg7(digit_val_s);
    end
`else
    seg_s = seg7(digit_val_s);
`endif
  end

  // State registers.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      presc_q    <= '0;
      sec_q      <= 8'h00;
      min_q      <= 8'h00;
      hr_q       <= 8'h00;
      alm_min_q  <= 8'h00;
      alm_hr_q   <= 8'h00;
      armed_q    <= 1'b0;
      segundo_q  <= 1'b1;
      alarma_q   <= 1'b0;
      min_sync_q <= 2'b00;
      hr_sync_q  <= 2'b00;
      min_prev_q <= 1'b0;
      hr_prev_q  <= 1'b0;
      scan_cnt_q <= '0;
      digit_q    <= 2'd0;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      alm_min_q  <= alm_min_d;
      alm_hr_q   <= alm_hr_d;
      armed_q    <= armed_d;
      segundo_q  <= segundo_d;
      alarma_q   <= alarma_d;
      min_sync_q <= min_sync_d;
      hr_sync_q  <= hr_sync_d;
      min_prev_q <= min_prev_d;
      hr_prev_q  <= hr_prev_d;
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
    end
  end

  assign Segundo      = segundo_q;
  assign alarma       = alarma_q;
  assign Sw0          = sw_s[0];
  assign Sw1          = sw_s[1];
  assign Sw2          = sw_s[2];
  assign Sw3          = sw_s[3];
  assign Displaytotal = seg_s;

endmodule

// File: tb/tb_reloj_main.sv
// Directed scoreboard bench for reloj_main at CLK_HZ=10, REFRESH_DIV=2.
module tb_reloj_main;

  localparam int CLK_HZ      = 10;
  localparam int REFRESH_DIV = 2;

  logic       clock = 1'b0;
  logic       Reset = 1'b1;
  logic       MoDe = 1'b0;
  logic       AjusTHora = 1'b0;
  logic       AjusTAlarma = 1'b0;
  logic       AumenMin = 1'b0;
  logic       AumenHora = 1'b0;
  logic       Segundo;
  logic       alarma;
  logic       Sw0, Sw1, Sw2, Sw3;
  logic [6:0] Displaytotal;

  int cyc;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];

  reloj_main #(.CLK_HZ(CLK_HZ), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clock(clock), .Reset(Reset), .MoDe(MoDe), .AjusTHora(AjusTHora),
    .AjusTAlarma(AjusTAlarma), .AumenMin(AumenMin), .AumenHora(AumenHora),
    .Segundo(Segundo), .alarma(alarma), .Sw0(Sw0), .Sw1(Sw1), .Sw2(Sw2), .Sw3(Sw3),
    .Displaytotal(Displaytotal)
  );

  always #5 clock = ~clock;

  // Rising edges since Reset was last released.
  always @(posedge clock or posedge Reset) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b1000000;
      1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;
      3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;
      5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;
      7: seg_of = 7'b1111000;
      8: seg_of = 7'b0000000;
      9: seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int pos, input int d);
`ifdef RELOJ_LEADING_ZERO_BLANK_EN
    if (pos == 3 && d == 0) return 7'b1111111;
`endif
    return seg_of(d);
  endfunction

  task automatic expect_val(input string tag, input logic [15:0] e);
    sb_t it;
    it.tag = tag;
    it.exp = e;
    sb_q.push_back(it);
  endtask

  task automatic check_val(input logic [15:0] obs);
    sb_t it;
    it = sb_q.pop_front();
    vectors++;
    assert (obs === it.exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] e);
    expect_val(tag, e);
    check_val(obs);
  endtask

  task automatic goto_cyc(input int n);
    if (cyc > n) chk("schedule", cyc[15:0], n[15:0]);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge clock);
    Reset = 1'b0;
  endtask

  task automatic press(input bit hour);
    if (hour) AumenHora = 1'b1;
    else      AumenMin  = 1'b1;
    repeat (2) @(negedge clock);
    AumenHora = 1'b0;
    AumenMin  = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  // Walk the scan through digits 0..3 and check enables and segments for HH:MM.
  task automatic read_disp(input string tag, input int h, input int m);
    int dig[4];
    logic [3:0] pat;
    dig[0] = m % 10;
    dig[1] = m / 10;
    dig[2] = h % 10;
    dig[3] = h / 10;
    for (int p = 0; p < 4; p++) begin
      int n;
      n = 0;
      pat = 4'b1111;
      pat[p] = 1'b0;
      while ({Sw3, Sw2, Sw1, Sw0} !== pat && n < 16) begin
        @(negedge clock);
        n++;
      end
      chk($sformatf("%s_sw%0d", tag, p), {12'h000, Sw3, Sw2, Sw1, Sw0}, {12'h000, pat});
      chk($sformatf("%s_seg%0d", tag, p), {9'h000, Displaytotal},
          {9'h000, exp_seg(p, dig[p])});
    end
  endtask

  initial begin
    int r;
    bit seen;

    // Reset state.
    @(negedge clock);
    chk("rst_sw", {12'h000, Sw3, Sw2, Sw1, Sw0}, 16'h000E);
    chk("rst_seg", {9'h000, Displaytotal}, {9'h000, 7'b1000000});
    chk("rst_alarma", {15'h0000, alarma}, 16'h0000);
    chk("rst_segundo", {15'h0000, Segundo}, 16'h0001);
    Reset = 1'b0;

    // Scan order and seconds indicator timing.
    goto_cyc(1);
    chk("scan_hold", {12'h000, Sw3, Sw2, Sw1, Sw0}, 16'h000E);
    goto_cyc(2);
    chk("scan_step", {12'h000, Sw3, Sw2, Sw1, Sw0}, 16'h000D);
    goto_cyc(4);
    chk("seg_hi4", {15'h0000, Segundo}, 16'h0001);
    goto_cyc(5);
    chk("seg_lo5", {15'h0000, Segundo}, 16'h0000);
    goto_cyc(10);
    chk("seg_hi10", {15'h0000, Segundo}, 16'h0001);

    // Free run for a minute; unarmed alarm must never fire at 00:00.
    seen = 1'b0;
    while (cyc < 590) begin
      @(negedge clock);
      seen = seen | alarma;
    end
    read_disp("run59", 0, 0);
    chk("noarm_alarma", {15'h0000, seen}, 16'h0000);
    goto_cyc(599);
    chk("run_seg599", {15'h0000, Segundo}, 16'h0000);
    goto_cyc(600);
    chk("run_seg600", {15'h0000, Segundo}, 16'h0001);
    read_disp("run60", 0, 1);

    // Time adjust: press latency on hours and minutes, then 03:01.
    do_reset();
    AjusTHora = 1'b1;
    goto_cyc(2);
    AumenHora = 1'b1;
    goto_cyc(4);
    chk("lat_hr_sw", {12'h000, Sw3, Sw2, Sw1, Sw0}, 16'h000B);
    chk("lat_hr_old", {9'h000, Displaytotal}, {9'h000, seg_of(0)});
    AumenHora = 1'b0;
    goto_cyc(5);
    chk("lat_hr_new", {9'h000, Displaytotal}, {9'h000, seg_of(1)});
    press(1'b1);
    press(1'b1);
    goto_cyc(22);
    AumenMin = 1'b1;
    goto_cyc(24);
    chk("lat_min_sw", {12'h000, Sw3, Sw2, Sw1, Sw0}, 16'h000E);
    chk("lat_min_old", {9'h000, Displaytotal}, {9'h000, seg_of(0)});
    AumenMin = 1'b0;
    goto_cyc(25);
    chk("lat_min_new", {9'h000, Displaytotal}, {9'h000, seg_of(1)});
    for (int i = 0; i < 60; i++) press(1'b0);
    chk("adj_segundo", {15'h0000, Segundo}, 16'h0001);
    read_disp("adj_time", 3, 1);
    MoDe = 1'b1;
    read_disp("adj_alm", 0, 0);
    MoDe = 1'b0;
    AjusTHora = 1'b0;

    // Preload 23:59:00 and roll over midnight.
    do_reset();
    AjusTHora = 1'b1;
    for (int i = 0; i < 23; i++) press(1'b1);
    for (int i = 0; i < 59; i++) press(1'b0);
    AjusTHora = 1'b0;
    r = cyc;
    goto_cyc(r + 580);
    read_disp("pre_roll", 23, 59);
    goto_cyc(r + 599);
    chk("roll_seg599", {15'h0000, Segundo}, 16'h0000);
    goto_cyc(r + 600);
    chk("roll_seg600", {15'h0000, Segundo}, 16'h0001);
    read_disp("roll", 0, 0);

    // Alarm at 00:01: rises on that minute, masked by adjust, falls at 00:02.
    do_reset();
    AjusTAlarma = 1'b1;
    press(1'b0);
    chk("alm_adj_mask", {15'h0000, alarma}, 16'h0000);
    AjusTAlarma = 1'b0;
    goto_cyc(599);
    chk("alm_pre", {15'h0000, alarma}, 16'h0000);
    goto_cyc(600);
    chk("alm_rise", {15'h0000, alarma}, 16'h0001);
    goto_cyc(700);
    MoDe = 1'b1;
    read_disp("alm_show", 0, 1);
    MoDe = 1'b0;
    read_disp("alm_time", 0, 1);
    goto_cyc(800);
    AjusTAlarma = 1'b1;
    goto_cyc(801);
    chk("alm_masked", {15'h0000, alarma}, 16'h0000);
    AjusTAlarma = 1'b0;
    goto_cyc(802);
    chk("alm_unmask", {15'h0000, alarma}, 16'h0001);
    goto_cyc(810);
    press(1'b0);
    press(1'b1);
    goto_cyc(830);
    read_disp("ign_time", 0, 1);
    MoDe = 1'b1;
    read_disp("ign_alm", 0, 1);
    MoDe = 1'b0;
    goto_cyc(1199);
    chk("alm_hold", {15'h0000, alarma}, 16'h0001);
    goto_cyc(1200);
    chk("alm_fall", {15'h0000, alarma}, 16'h0000);

    // Reset mid-operation clears scan, display and seconds phase at once.
    goto_cyc(1205);
    Reset = 1'b1;
    #1;
    chk("mid_rst_sw", {12'h000, Sw3, Sw2, Sw1, Sw0}, 16'h000E);
    chk("mid_rst_seg", {9'h000, Displaytotal}, {9'h000, 7'b1000000});
    chk("mid_rst_segundo", {15'h0000, Segundo}, 16'h0001);
    chk("mid_rst_alarma", {15'h0000, alarma}, 16'h0000);
    @(negedge clock);
    Reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
